stereo_row_sequencer: RTL
=========================

Name: stereo_row_sequencer

Overview:
Sequential controller that drives the combinational stereo_solver across one image row. On a start pulse it steps mask_position over every valid column and derives the matching match_position for each. It waits a configurable settle latency, captures DISSPARITION and emits one disparity per column on a valid/ready stream. It sits between the row line-buffer logic (which presents flattern_mask/flattern_match_array for the current positions) and the disparity writer.

Parameters:
MASK_SIZE, 5, mask edge in pixels (odd); half = MASK_SIZE/2
MATCH_WIDE, 18, match window width in pixels; search span S = MATCH_WIDE - MASK_SIZE
POSITION_BITS, 8, width of column/position counters
SOLVER_LATENCY, 1, cycles positions are held before capture (0 = capture in issue cycle)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  single-cycle row start request; honoured only in IDLE
row_width  in  POSITION_BITS  row length in pixels; sampled on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of row
mask_position  out  POSITION_BITS  to stereo_solver
match_position  out  POSITION_BITS  to stereo_solver
solver_disparity  in  8  DISSPARITION from stereo_solver
disp_valid  out  1  output disparity valid
disp_ready  in  1  downstream accept
disp_data  out  8  captured disparity
disp_column  out  POSITION_BITS  column of disp_data

Behaviour:
- Reset (rst_n low at posedge): state IDLE; all outputs 0; counters 0. Applies mid-row: the row is abandoned, with no done and no further valid.
- States: IDLE, ISSUE, WAIT, OUTPUT, DONE.
- IDLE: start=1 latches row_width into W.
  - W < MASK_SIZE: go to DONE; no outputs.
  - Otherwise column c = half; go to ISSUE.
- ISSUE: mask_position = c; match_position = (c >= S) ? c - S : 0 (saturating, never wraps). Both are held stable through WAIT until capture. Wait counter loads SOLVER_LATENCY.
  - SOLVER_LATENCY = 0: capture solver_disparity at the end of this cycle, go to OUTPUT.
  - Otherwise go to WAIT.
- WAIT: decrement counter; when it reaches 1, capture at the end of that cycle and go to OUTPUT. Total hold is exactly SOLVER_LATENCY+1 cycles including ISSUE.
- OUTPUT: disp_valid=1; disp_data and disp_column (= c) are stable while disp_ready=0.
  - On valid&&ready: if c == W-1-half, go to DONE; else c <= c+1 and go to ISSUE.
  - disp_valid drops in the cycle after the handshake.
- DONE: done=1 for exactly one cycle, then IDLE. busy is still high in DONE and low in the cycle after.
- start in any non-IDLE state is ignored; row_width changes after acceptance are ignored.
- Max throughput: one column per SOLVER_LATENCY+2 cycles with disp_ready tied high.
- Outputs per row = W - 2*half when W >= MASK_SIZE, else 0.
- Arithmetic is unsigned POSITION_BITS. W-1-half is computed from the latched W. W = 2^POSITION_BITS-1 must not overflow c.

Decomposition:
- Shared package stereo_pkg: default MASK_SIZE, MATCH_WIDE, POSITION_BITS, pixel width 8, disparity width 8, state encoding constants. The same package is used by stereo_solver and the line buffers.
- One sub-module, stereo_window_addr: combinational; maps c to mask_position/match_position with the saturating subtraction. It is reusable by the line-buffer read side.

Test Plan:
- Defaults, SOLVER_LATENCY=1, W=20, disp_ready=1, solver stub = mask_position - match_position -> 16 outputs, columns 2..17. Column 2: match_position 0, disp 2. Column 15: match_position 2, disp 13. Column 17: match_position 4, disp 13. done pulses once after column 17; 3 cycles per column.
- Backpressure: same row, disp_ready low for 3 cycles at column 5 -> disp_valid, disp_data=5, disp_column=5 held constant; column 6 issued only after the handshake; still 16 outputs total.
- Degenerate row: W=4 -> no disp_valid; done high exactly 2 cycles after the start edge; busy high 1 cycle.
- start pulsed while busy at column 8, row_width changed to 30 -> ignored; row still ends at column 17.
- Reset mid-row: rst_n low one cycle during WAIT at column 10 -> next cycle all outputs 0 and state IDLE; no done. A new start with W=6 yields columns 2,3.
- SOLVER_LATENCY=0 and SOLVER_LATENCY=3, W=8 -> 4 outputs each; capture aligned to the ISSUE cycle / 4th hold cycle, checked by changing the stub value on the cycle after capture.

Source files
------------

// File: rtl/stereo_pkg.sv
// Shared stereo-pipeline constants and the row-sequencer state encoding.
// Used by the solver, the line buffers and the row sequencer.
package stereo_pkg;
    localparam int MASK_SIZE_DEF     = 5;
    localparam int MATCH_WIDE_DEF    = 18;
    localparam int POSITION_BITS_DEF = 8;
    localparam int PIXEL_BITS        = 8;
    localparam int DISP_BITS         = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;
endpackage

// File: rtl/stereo_window_addr.sv
// Maps a centre column to solver mask/match positions (combinational, no state).
// The match side saturates at 0 near the left edge instead of wrapping.
module stereo_window_addr
    import stereo_pkg::*;
#(
    parameter int MASK_SIZE     = MASK_SIZE_DEF,
    parameter int MATCH_WIDE    = MATCH_WIDE_DEF,
    parameter int POSITION_BITS = POSITION_BITS_DEF
) (
    input  logic [POSITION_BITS-1:0] column,
    output logic [POSITION_BITS-1:0] mask_position,
    output logic [POSITION_BITS-1:0] match_position
);
    localparam int SPAN = MATCH_WIDE - MASK_SIZE;
    localparam logic [POSITION_BITS-1:0] SPAN_W = POSITION_BITS'(SPAN);

    assign mask_position  = column;
    assign match_position = (column >= SPAN_W) ? column - SPAN_W : '0;
endmodule

// File: rtl/stereo_row_sequencer.sv
// Steps the stereo solver across one row; one disparity per SOLVER_LATENCY+2 cycles.
// Positions and disp_data/disp_column are held while disp_ready is low.
module stereo_row_sequencer
    import stereo_pkg::*;
#(
    parameter int MASK_SIZE      = MASK_SIZE_DEF,
    parameter int MATCH_WIDE     = MATCH_WIDE_DEF,
    parameter int POSITION_BITS  = POSITION_BITS_DEF,
    parameter int SOLVER_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [POSITION_BITS-1:0] row_width,
    output logic                     busy,
    output logic                     done,
    output logic [POSITION_BITS-1:0] mask_position,
    output logic [POSITION_BITS-1:0] match_position,
    input  logic [DISP_BITS-1:0]     solver_disparity,
    output logic                     disp_valid,
    input  logic                     disp_ready,
    output logic [DISP_BITS-1:0]     disp_data,
    output logic [POSITION_BITS-1:0] disp_column
);
    localparam int HALF     = MASK_SIZE / 2;
    localparam int CNT_BITS = (SOLVER_LATENCY > 0) ? $clog2(SOLVER_LATENCY + 1) : 1;
    localparam logic [POSITION_BITS-1:0] HALF_W = POSITION_BITS'(HALF);
    localparam logic [POSITION_BITS-1:0] MASK_W = POSITION_BITS'(MASK_SIZE);
    localparam logic [POSITION_BITS-1:0] ONE_W  = POSITION_BITS'(1);
    localparam logic [CNT_BITS-1:0]      LAT_W  = CNT_BITS'(SOLVER_LATENCY);
    localparam logic [CNT_BITS-1:0]      CNT_1  = CNT_BITS'(1);

    seq_state_t               state, state_nxt;
    logic [POSITION_BITS-1:0] col, last_col;
    logic [CNT_BITS-1:0]      wait_cnt;
    logic                     accept, capture, advance;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (row_width < MASK_W) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (SOLVER_LATENCY == 0) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUTPUT;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == CNT_1) begin
                    capture   = 1'b1;
                    state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (disp_ready) begin
                    if (col == last_col) begin
                        state_nxt = ST_DONE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            last_col  <= '0;
            wait_cnt  <= '0;
            disp_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                col      <= HALF_W;
                // last_col < row_width, so col never has to count past it
                last_col <= row_width - HALF_W - ONE_W;
            end else if (advance) begin
                col <= col + ONE_W;
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= LAT_W;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - CNT_1;
            end
            if (capture) begin
                disp_data <= solver_disparity;
            end
        end
    end

    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);
    assign disp_valid  = (state == ST_OUTPUT);
    assign disp_column = col;

    stereo_window_addr #(
        .MASK_SIZE     (MASK_SIZE),
        .MATCH_WIDE    (MATCH_WIDE),
        .POSITION_BITS (POSITION_BITS)
    ) u_window_addr (
        .column         (col),
        .mask_position  (mask_position),
        .match_position (match_position)
    );
endmodule
